apb4_cmd_master: RTL and testbench
==================================

APB4_CMD_MASTER -- requirements
Module: apb4_cmd_master

Interface
REQ-001 Param ADDR_W, default 16, APB address width.
REQ-002 Param DATA_W, default 32, data width; SHALL be a multiple of 8.
REQ-003 Param DEPTH, default 4, command FIFO entries; SHALL be a power of 2 and at least 2.
REQ-004 Param TIMEOUT, default 16, max ACCESS wait cycles; 0 disables the timeout.
REQ-005 pclk  in  1  the only clock; all state updates on its rising edge.
REQ-006 presetn  in  1  asynchronous, active-low reset.
REQ-007 cmd_valid in 1, cmd_ready out 1: command handshake.
REQ-008 cmd_write in 1, cmd_addr in ADDR_W, cmd_wdata in DATA_W, cmd_strb in DATA_W/8, cmd_prot in 3: command fields.
REQ-009 rsp_valid out 1, rsp_rdata out DATA_W, rsp_err out 1, rsp_timeout out 1: response, one-cycle pulse.
REQ-010 busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.
REQ-011 psel, penable, pwrite out 1; paddr out ADDR_W; pwdata out DATA_W; pstrb out DATA_W/8; pprot out 3: APB4 requester outputs, all registered.
REQ-012 pready in 1, prdata in DATA_W, pslverr in 1: APB4 completer inputs.

Function
REQ-013 A command SHALL be accepted on an edge with cmd_valid and cmd_ready both high; cmd_ready SHALL equal NOT full, derived from the registered count (no same-cycle pop bypass).
REQ-014 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-015 IDLE: on an edge with the FIFO non-empty, pop the head, load paddr/pwrite/pwdata/pstrb/pprot, set psel=1 and penable=0, and go to SETUP.
REQ-016 SETUP: unconditionally set penable=1 and go to ACCESS; the APB outputs SHALL be held stable.
REQ-017 ACCESS with pready=1: pulse rsp_valid for one cycle, set rsp_err=pslverr, and set rsp_rdata=prdata for reads or 0 for writes.
REQ-018 ACCESS completion with the FIFO non-empty: go directly to SETUP with the next head (psel stays 1, penable=0); with the FIFO empty: go to IDLE with psel=0 and penable=0.
REQ-019 For a read, pstrb SHALL be driven to 0 regardless of cmd_strb; pwdata for a read is don't-care, but a bench SHALL see it hold its previous value.
REQ-020 Minimum latency: a command accepted at edge N into an empty FIFO while IDLE SHALL give psel=1 after edge N+1 and penable=1 after N+2; with a zero-wait completer, rsp_valid is high after N+3.
REQ-021 Timeout (TIMEOUT>0): a counter SHALL count ACCESS cycles with pready=0; if it reaches TIMEOUT, the transfer is aborted with rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, and the FSM proceeds as in REQ-018.
REQ-022 The timeout counter SHALL clear on entering SETUP and SHALL saturate; if pready=1 on the same edge the counter hits TIMEOUT, the completion SHALL take priority (rsp_timeout=0).
REQ-023 Push and pop on the same edge SHALL leave the count unchanged; FIFO pointers SHALL wrap modulo DEPTH.
REQ-024 Responses SHALL be issued in command acceptance order; there is no response backpressure.

Reset
REQ-025 When presetn is low, the block SHALL immediately (asynchronously) clear psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, rsp_rdata, rsp_err, rsp_timeout and the timeout counter; set the state to IDLE; and empty the FIFO, so cmd_ready=1 and busy=0.
REQ-026 A reset during SETUP or ACCESS SHALL abort the transfer with no response; queued commands are discarded.
REQ-027 After presetn rises, the first accepted command SHALL follow REQ-020 timing.

Structure
REQ-028 FSM state encodings and the APB4 PPROT bit constants SHALL live in the shared package apb_pkg.
REQ-029 The command FIFO SHALL be the sub-module apb_cmd_fifo (parameters DEPTH and the packed command width; outputs full, empty and count).

Verification
REQ-030 Single write: addr 0x0010, wdata 0xDEADBEEF, strb 0xF, zero-wait completer -> SETUP then ACCESS, pstrb=0xF, rsp_valid after edge N+3, rsp_err=0.
REQ-031 Read, completer 2 wait states, prdata 0x12345678 -> penable high for 3 cycles, pstrb=0, rsp_rdata=0x12345678.
REQ-032 Push 5 commands back-to-back with DEPTH=4 and a stalled completer -> cmd_ready low once 4 entries are queued; all 5 complete in order; psel never drops between transfers.
REQ-033 Completer never asserts pready with TIMEOUT=16 -> after 16 ACCESS cycles, rsp_valid=1 with rsp_err=1 and rsp_timeout=1; the next command proceeds normally.
REQ-034 pslverr=1 with pready on a write -> rsp_err=1, rsp_timeout=0; pready coinciding with the timeout edge -> rsp_timeout=0.
REQ-035 presetn pulsed low mid-ACCESS with 2 commands queued -> psel and penable drop immediately with no clock edge needed, no rsp_valid, busy=0, cmd_ready=1.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB4 command master: FSM state encoding, PPROT bits, command packing width.
// Latency: none, constants and a pure helper function only.
// Backpressure: not applicable.
package apb_pkg;

  // Transfer phases of the APB4 requester.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  // PPROT bit meanings: [0] privileged, [1] non-secure, [2] instruction fetch.
  localparam logic [2:0] PPROT_PRIV   = 3'b001;
  localparam logic [2:0] PPROT_NONSEC = 3'b010;
  localparam logic [2:0] PPROT_INSTR  = 3'b100;

  // Width of one queued command: {write, addr, wdata, strb, prot}.
  function automatic int cmd_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + (data_w / 8) + 3;
  endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Command queue between the command handshake and the APB FSM, DEPTH entries of WIDTH bits.
// Latency: a push is visible at the head one cycle later; pop data is read combinationally from the head.
// Backpressure: full is taken from the registered count only; a push while full or a pop while empty is ignored.
module apb_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  // Entry storage; contents need no reset because count gates every read.
  always_ff @(posedge pclk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; simultaneous push and pop leave count unchanged.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/apb4_cmd_master.sv
// APB4 requester: queues commands in a FIFO and runs them as SETUP/ACCESS transfers, one response per command.
// Latency: command accepted at edge N into an idle, empty block -> psel after N+1, penable after N+2, response after N+3 at zero wait.
// Backpressure: cmd_ready drops while the FIFO is full; responses are never stalled and come out in acceptance order.
module apb4_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                presetn,
  // command side
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  input  logic [2:0]          cmd_prot,
  // response side
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                busy,
  // APB4 requester
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  output logic [2:0]          pprot,
  input  logic                pready,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CMD_W  = cmd_width(ADDR_W, DATA_W);
  // One spare state above TIMEOUT lets the counter saturate without wrapping.
  localparam int TCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT);

  apb_state_t           state;
  apb_state_t           state_nxt;

  logic [CMD_W-1:0]     fifo_din;
  logic [CMD_W-1:0]     fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                 fifo_push;
  logic                 fifo_pop;

  logic                 h_write;
  logic [ADDR_W-1:0]    h_addr;
  logic [DATA_W-1:0]    h_wdata;
  logic [STRB_W-1:0]    h_strb;
  logic [2:0]           h_prot;

  logic                 load_head;
  logic                 xfer_end;
  logic                 psel_nxt;
  logic                 penable_nxt;
  logic [TCNT_W-1:0]    tcnt;
  logic [TCNT_W-1:0]    tcnt_nxt;
  logic                 rsp_valid_nxt;
  logic [DATA_W-1:0]    rsp_rdata_nxt;
  logic                 rsp_err_nxt;
  logic                 rsp_timeout_nxt;

  assign cmd_ready = ~fifo_full;
  assign fifo_push = cmd_valid & cmd_ready;
  assign fifo_din  = {cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot};
  assign {h_write, h_addr, h_wdata, h_strb, h_prot} = fifo_dout;
  assign busy      = (fifo_count != '0) || (state != ST_IDLE);

  apb_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .pclk     (pclk),
    .presetn  (presetn),
    .push     (fifo_push),
    .push_dat (fifo_din),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Next state and next registered outputs; a completion or timeout chains straight into the next SETUP when work is queued.
  always_comb begin
    state_nxt       = state;
    fifo_pop        = 1'b0;
    load_head       = 1'b0;
    xfer_end        = 1'b0;
    psel_nxt        = psel;
    penable_nxt     = penable;
    tcnt_nxt        = tcnt;
    rsp_valid_nxt   = 1'b0;
    rsp_rdata_nxt   = '0;
    rsp_err_nxt     = 1'b0;
    rsp_timeout_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          load_head   = 1'b1;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          tcnt_nxt    = '0;
          state_nxt   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_nxt = 1'b1;
        state_nxt   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (pready) begin
          // A real completion wins over a timeout landing on the same edge.
          xfer_end      = 1'b1;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = pslverr;
          rsp_rdata_nxt = pwrite ? '0 : prdata;
        end else if (TIMEOUT > 0) begin
          if (tcnt != TCNT_MAX) begin
            tcnt_nxt = tcnt + 1'b1;
          end
          if (tcnt_nxt == TCNT_MAX) begin
            xfer_end        = 1'b1;
            rsp_valid_nxt   = 1'b1;
            rsp_err_nxt     = 1'b1;
            rsp_timeout_nxt = 1'b1;
          end
        end

        if (xfer_end) begin
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            load_head   = 1'b1;
            penable_nxt = 1'b0;
            tcnt_nxt    = '0;
            state_nxt   = ST_SETUP;
          end else begin
            psel_nxt    = 1'b0;
            penable_nxt = 1'b0;
            state_nxt   = ST_IDLE;
          end
        end
      end

      default: begin
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
        state_nxt   = ST_IDLE;
      end
    endcase
  end

  // State, APB outputs, response pulse and timeout counter; reset aborts any transfer without a response.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state       <= ST_IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      pprot       <= '0;
      tcnt        <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      psel        <= psel_nxt;
      penable     <= penable_nxt;
      tcnt        <= tcnt_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
      if (load_head) begin
        paddr  <= h_addr;
        pwrite <= h_write;
        pprot  <= h_prot;
        // Reads carry no byte lanes and leave pwdata where it was.
        pstrb  <= h_write ? h_strb : '0;
        if (h_write) begin
          pwdata <= h_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb4_cmd_master.sv
// Directed bench for apb4_cmd_master with a wait-state-configurable completer and a response scoreboard.
module tb_apb4_cmd_master;
  import apb_pkg::*;

  logic        pclk;
  logic        presetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;

  exp_t        exp_q[$];
  int          checks;
  int          errors;

  // completer behaviour knobs
  int          wait_cfg;
  bit          hang_cfg;
  bit          err_cfg;
  logic [31:0] rdata_cfg;

  apb4_cmd_master #(
    .ADDR_W  (16),
    .DATA_W  (32),
    .DEPTH   (4),
    .TIMEOUT (16)
  ) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .cmd_prot    (cmd_prot),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pstrb       (pstrb),
    .pprot       (pprot),
    .pready      (pready),
    .prdata      (prdata),
    .pslverr     (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk_exp(input logic [31:0] r, input logic e, input logic t);
    exp_t x;
    x.rdata = r;
    x.err   = e;
    x.to    = t;
    return x;
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Offer one command, wait (bounded) for acceptance, log its expected response.
  task automatic send(input logic w, input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p, input exp_t e);
    int g;
    g = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_prot  = p;
    while (cmd_ready !== 1'b1 && g < 200) begin
      tick();
      g++;
    end
    chk("send_cmd_ready", 64'(cmd_ready), 64'd1);
    exp_q.push_back(e);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 400) begin
      tick();
      g++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  // Completer model: pready after wait_cfg wait states unless hung; prdata depends on paddr.
  initial begin
    int wcnt;
    wcnt    = 0;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    forever begin
      @(negedge pclk);
      prdata  = rdata_cfg + {16'h0, paddr};
      pslverr = err_cfg;
      if (psel === 1'b1 && penable === 1'b1) begin
        if (!hang_cfg && wcnt >= wait_cfg) begin
          pready = 1'b1;
          wcnt   = 0;
        end else begin
          pready = 1'b0;
          wcnt++;
        end
      end else begin
        pready = 1'b0;
        wcnt   = 0;
      end
    end
  end

  // Scoreboard: every response pulse is matched in order against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      if (presetn === 1'b1 && rsp_valid === 1'b1) begin
        chk("rsp_outstanding", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("sb_err", 64'(rsp_err), 64'(e.err));
          chk("sb_timeout", 64'(rsp_timeout), 64'(e.to));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int g;
    int drops;
    logic [15:0] a;

    checks    = 0;
    errors    = 0;
    presetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    cmd_prot  = '0;
    wait_cfg  = 0;
    hang_cfg  = 1'b0;
    err_cfg   = 1'b0;
    rdata_cfg = 32'h1234_5678;

    // reset state
    #1;
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_penable", 64'(penable), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_pstrb", 64'(pstrb), 64'd0);
    tick();
    tick();
    presetn = 1'b1;
    tick();

    // single zero-wait write, cycle-exact latency
    send(1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF, PPROT_PRIV | PPROT_NONSEC, mk_exp(32'h0, 1'b0, 1'b0));
    chk("wr_psel_n0", 64'(psel), 64'd0);
    chk("wr_busy_n0", 64'(busy), 64'd1);
    tick();
    chk("wr_psel_n1", 64'(psel), 64'd1);
    chk("wr_penable_n1", 64'(penable), 64'd0);
    chk("wr_pwrite", 64'(pwrite), 64'd1);
    chk("wr_paddr", 64'(paddr), 64'h0010);
    chk("wr_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
    chk("wr_pstrb", 64'(pstrb), 64'hF);
    chk("wr_pprot", 64'(pprot), 64'h3);
    tick();
    chk("wr_penable_n2", 64'(penable), 64'd1);
    chk("wr_psel_n2", 64'(psel), 64'd1);
    chk("wr_rsp_n2", 64'(rsp_valid), 64'd0);
    tick();
    chk("wr_rsp_n3", 64'(rsp_valid), 64'd1);
    chk("wr_rsp_err", 64'(rsp_err), 64'd0);
    tick();
    chk("wr_psel_idle", 64'(psel), 64'd0);
    chk("wr_rsp_pulse", 64'(rsp_valid), 64'd0);
    chk("wr_busy_idle", 64'(busy), 64'd0);

    // read with two wait states
    wait_cfg = 2;
    send(1'b0, 16'h0000, 32'hCAFE_F00D, 4'hF, 3'b000, mk_exp(32'h1234_5678, 1'b0, 1'b0));
    tick();
    chk("rd_pwrite", 64'(pwrite), 64'd0);
    chk("rd_pstrb", 64'(pstrb), 64'd0);
    chk("rd_pwdata_hold", 64'(pwdata), 64'hDEAD_BEEF);
    tick();
    cyc = 0;
    while (penable === 1'b1 && cyc < 40) begin
      cyc++;
      tick();
    end
    chk("rd_penable_cycles", 64'(cyc), 64'd3);
    chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rd_rsp_rdata", 64'(rsp_rdata), 64'h1234_5678);
    drain("rd_drain");

    // five back-to-back commands into a depth-4 queue behind a stalled completer
    hang_cfg = 1'b1;
    wait_cfg = 0;
    for (int i = 0; i < 5; i++) begin
      a = 16'h0100 + 16'(i * 4);
      if (i % 2 == 1)
        send(1'b1, a, 32'hA000_0000 + 32'(i), 4'h5, 3'(i), mk_exp(32'h0, 1'b0, 1'b0));
      else
        send(1'b0, a, 32'h0, 4'hF, 3'(i), mk_exp(rdata_cfg + {16'h0, a}, 1'b0, 1'b0));
    end
    chk("b2b_cmd_ready_full", 64'(cmd_ready), 64'd0);
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_stalled_access", 64'(penable), 64'd1);
    hang_cfg = 1'b0;
    wait_cfg = 1;
    g = 0;
    drops = 0;
    while (exp_q.size() != 0 && g < 400) begin
      if (exp_q.size() > 1 && psel !== 1'b1) drops++;
      tick();
      g++;
    end
    chk("b2b_drain", 64'(exp_q.size()), 64'd0);
    chk("b2b_psel_gaps", 64'(drops), 64'd0);
    chk("b2b_cmd_ready_back", 64'(cmd_ready), 64'd1);
    tick();

    // timeout on a completer that never answers, then a normal command
    hang_cfg = 1'b1;
    wait_cfg = 0;
    send(1'b0, 16'h0020, 32'h0, 4'hF, 3'b000, mk_exp(32'h0, 1'b1, 1'b1));
    tick();
    tick();
    cyc = 0;
    while (penable === 1'b1 && cyc < 40) begin
      cyc++;
      tick();
    end
    chk("to_access_cycles", 64'(cyc), 64'd16);
    chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("to_rsp_err", 64'(rsp_err), 64'd1);
    chk("to_rsp_timeout", 64'(rsp_timeout), 64'd1);
    chk("to_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("to_psel_drop", 64'(psel), 64'd0);
    hang_cfg = 1'b0;
    send(1'b1, 16'h0030, 32'h1111_2222, 4'h3, 3'b000, mk_exp(32'h0, 1'b0, 1'b0));
    drain("to_next_drain");

    // slave error on a write
    err_cfg = 1'b1;
    send(1'b1, 16'h0040, 32'h5555_AAAA, 4'hC, 3'b000, mk_exp(32'h0, 1'b1, 1'b0));
    drain("slverr_drain");
    err_cfg = 1'b0;

    // pready arriving on the very edge the timeout would fire
    wait_cfg = 15;
    send(1'b0, 16'h0004, 32'h0, 4'hF, 3'b000, mk_exp(rdata_cfg + 32'h4, 1'b0, 1'b0));
    tick();
    tick();
    cyc = 0;
    while (penable === 1'b1 && cyc < 40) begin
      cyc++;
      tick();
    end
    chk("edge_access_cycles", 64'(cyc), 64'd16);
    chk("edge_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("edge_rsp_timeout", 64'(rsp_timeout), 64'd0);
    drain("edge_drain");
    wait_cfg = 0;

    // asynchronous reset mid-ACCESS with two commands queued
    hang_cfg = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 16'h0200 + 16'(i), 32'h0, 4'hF, 3'b000, mk_exp(32'h0, 1'b0, 1'b0));
    end
    chk("arst_pre_access", 64'(penable), 64'd1);
    chk("arst_pre_busy", 64'(busy), 64'd1);
    #2;
    presetn = 1'b0;
    #1;
    chk("arst_psel", 64'(psel), 64'd0);
    chk("arst_penable", 64'(penable), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    exp_q.delete();
    tick();
    tick();
    hang_cfg = 1'b0;
    presetn  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arst_no_rsp", 64'(rsp_valid), 64'd0);
      chk("arst_stays_idle", 64'(psel), 64'd0);
    end

    // first command after reset keeps minimum latency
    send(1'b1, 16'h0050, 32'h0BAD_CAFE, 4'hF, 3'b000, mk_exp(32'h0, 1'b0, 1'b0));
    chk("post_psel_n0", 64'(psel), 64'd0);
    tick();
    chk("post_psel_n1", 64'(psel), 64'd1);
    chk("post_paddr_n1", 64'(paddr), 64'h0050);
    tick();
    chk("post_penable_n2", 64'(penable), 64'd1);
    tick();
    chk("post_rsp_n3", 64'(rsp_valid), 64'd1);
    drain("post_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
